// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the MEM-stage load/store port.
// Accepts one request at a time, waits LATENCY edges, then accesses an
// internal word-organised RAM and returns size-extended load data or a
// store acknowledge as a one-cycle resp_valid pulse.
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses flag resp_err, no store commit,
//               resp_rdata=0.
//   undefined : resp_err stays 0; low address bits are forced aligned.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   req_we               1 = store, 0 = load
//   req_funct3           size/sign code
//   req_addr, req_wdata  byte address and store data
//   resp_valid           one-cycle response pulse
//   resp_rdata           extended load data (0 for stores)
//   resp_err             misalignment flag
//   mem_stall            combinational pipeline hold request
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_stall
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_d, valid_d, err_d;
  logic [31:0]   rdata_d;

  logic          we_q;
  logic [2:0]    f3_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic          fire;
  logic          is_byte, is_half, misaligned, mem_wr;
  logic [1:0]    off;
  logic [3:0]    be;
  logic [AW-1:0] idx;
  logic [31:0]   wword, rword, load_val;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;

  // Address bits above the RAM span only alias; they are intentionally dropped.
  logic unused_addr;
  assign unused_addr = ^req_addr[31:AW+2];

  assign accept    = req_valid && req_ready;
  assign fire      = (state_q == WAIT) && (cnt_q == '0);
  assign mem_stall = req_valid && (state_q != RESP);

  // Request capture; inputs are ignored once accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
    end else if (accept) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      addr_q  <= req_addr[AW+1:0];
      wdata_q <= req_wdata;
    end
  end

  // Access decode: size, lane offset, byte enables and load extension.
  always_comb begin
    // Loads treat bit 2 as the unsigned flag; stores treat anything but sb/sh as sw.
    is_byte = we_q ? (f3_q == 3'b000) : (f3_q[1:0] == 2'b00);
    is_half = we_q ? (f3_q == 3'b001) : (f3_q[1:0] == 2'b01);
    idx     = addr_q[AW+1:2];
`ifdef DMEM_MISALIGN_TRAP_EN
    off        = addr_q[1:0];
    misaligned = is_half ? addr_q[0] : (!is_byte && (addr_q[1:0] != 2'b00));
`else
    misaligned = 1'b0;
    off        = is_byte ? addr_q[1:0] : (is_half ? {addr_q[1], 1'b0} : 2'b00);
`endif
    be       = is_byte ? (4'b0001 << off) : (is_half ? (4'b0011 << off) : 4'b1111);
    wword    = is_byte ? {4{wdata_q[7:0]}} : (is_half ? {2{wdata_q[15:0]}} : wdata_q);
    rword    = mem[idx];
    byte_v   = rword[{off, 3'b000} +: 8];
    half_v   = rword[{off[1], 4'b0000} +: 16];
    if (is_byte) begin
      load_val = f3_q[2] ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
    end else if (is_half) begin
      load_val = f3_q[2] ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
    end else begin
      load_val = rword;
    end
    mem_wr = fire && we_q && !misaligned;
  end

  // RAM: byte-enable write on the commit edge; contents are not reset.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_ready  <= ready_d;
      resp_valid <= valid_d;
      resp_rdata <= rdata_d;
      resp_err   <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = 1'b0;
    valid_d = 1'b0;
    rdata_d = resp_rdata;
    err_d   = resp_err;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          state_d = WAIT;
          cnt_d   = CW'(LATENCY - 1);
          ready_d = 1'b0;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Access edge: response data is captured together with the RAM access.
          state_d = RESP;
          valid_d = 1'b1;
          rdata_d = (we_q || misaligned) ? 32'h0 : load_val;
          err_d   = misaligned;
        end
      end
      RESP: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

endmodule
